modulo_residual_diff: RTL and testbench

Front-end stage of the unlimited-sampling recovery path. Accepts folded modulo samples y[k] in [-LAMBDA, LAMBDA) and computes the ORDER-th finite difference Δᴺy. It folds that difference back into [-LAMBDA, LAMBDA) and emits the residual difference M_λ(Δᴺy) − Δᴺy, which is always an integer multiple of 2·LAMBDA. Its output feeds anti_difference_rounding directly, with matching WIDTH and LAMBDA.

---
 rtl/usf_pkg.sv | 32 +++
 rtl/modulo_fold.sv | 15 +
 rtl/modulo_residual_diff.sv | 101 ++++++++++
 tb/tb_modulo_residual_diff.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/usf_pkg.sv
// Shared constants and helpers for the unlimited-sampling recovery path.
package usf_pkg;

  // Binomial coefficient C(n, k) for small difference orders.
  function automatic int binom(input int n, input int k);
    int c;
    c = 1;
    for (int i = 0; i < k; i++) begin
      c = c * (n - i) / (i + 1);
    end
    return c;
  endfunction

  // Internal difference width: the Nth difference of WIDTH-bit samples
  // grows by at most ORDER bits, plus one bit of margin.
  function automatic int calc_dw(input int width, input int order);
    return width + order + 1;
  endfunction

  // Fold a value into [-lambda, lambda) with period 2*lambda, using the
  // non-negative modulo so negative inputs wrap the same way as positive.
  function automatic logic signed [63:0] fold(input logic signed [63:0] d,
                                              input int lambda);
    logic signed [63:0] p;
    logic signed [63:0] m;
    p = 64'(2 * lambda);
    m = (d + 64'(lambda)) % p;
    if (m < 0) m = m + p;
    return m - 64'(lambda);
  endfunction

endpackage

// File: rtl/modulo_fold.sv
// Combinational fold of a wide difference into [-LAMBDA, LAMBDA).
module modulo_fold
  import usf_pkg::*;
#(
  parameter int DW     = 18,
  parameter int LAMBDA = 10
) (
  input  logic signed [DW-1:0] d,
  output logic signed [DW-1:0] f
);

  // The mod-by-constant path lives here alone so it can be timed in isolation.
  assign f = DW'(fold(64'(d), LAMBDA));

endmodule

// File: rtl/modulo_residual_diff.sv
// Nth finite difference of folded samples, emitting M(d) - d, which is
// always a multiple of 2*LAMBDA.
module modulo_residual_diff
  import usf_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int LAMBDA = 10,
  parameter int ORDER  = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    valid_in,
  input  logic signed [WIDTH-1:0] sample_in,
  output logic                    valid_out,
  output logic signed [WIDTH-1:0] residual_diff_out,
  output logic                    range_err
);

  localparam int DW = calc_dw(WIDTH, ORDER);
  localparam int CW = $clog2(ORDER + 1);
  localparam logic signed [WIDTH-1:0] LO = WIDTH'(-LAMBDA);
  localparam logic signed [WIDTH-1:0] HI = WIDTH'(LAMBDA - 1);

  if (((64'sd1 << ORDER) + 64'sd1) * 64'(LAMBDA) >= (64'sd1 << (WIDTH - 1)) ||
      ORDER < 1 || ORDER > 4 || LAMBDA < 1) begin : g_param_check
    $fatal(1, "modulo_residual_diff: illegal WIDTH/LAMBDA/ORDER combination");
  end

  logic signed [WIDTH-1:0] hist [1:ORDER];
  logic [CW-1:0]           count;
  logic signed [DW-1:0]    taps [0:ORDER];
  logic signed [DW-1:0]    diff;
  logic signed [DW-1:0]    coef;
  logic signed [DW-1:0]    d1;
  logic                    valid1;
  logic signed [DW-1:0]    folded;
  logic signed [DW-1:0]    resid;
  logic                    warm;
  logic                    out_of_range;

  assign warm         = (count == CW'(ORDER));
  assign out_of_range = (sample_in < LO) || (sample_in > HI);

  // Signed binomial-weighted sum of the current sample and the history.
  always_comb begin
    // NOTE: every variable gets a default before any branch so no latch is inferred.
    diff    = '0;
    coef    = '0;
    taps[0] = DW'(sample_in);
    for (int i = 1; i <= ORDER; i++) taps[i] = DW'(hist[i]);
    for (int i = 0; i <= ORDER; i++) begin
      coef = DW'(binom(ORDER, i));
      if (i % 2 == 0) diff = diff + coef * taps[i];
      else            diff = diff - coef * taps[i];
    end
  end

  // Stage 1: history shift, warm-up count, range flag, and registered difference.
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: the history is small and must restart from zero, so it is reset like any flop.
      for (int i = 1; i <= ORDER; i++) hist[i] <= '0;
      count     <= '0;
      d1        <= '0;
      valid1    <= 1'b0;
      range_err <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      valid1 <= valid_in && warm;
      if (valid_in) begin
        d1      <= diff;
        hist[1] <= sample_in;
        for (int i = 2; i <= ORDER; i++) hist[i] <= hist[i-1];
        if (!warm) count <= count + CW'(1);
        if (out_of_range) range_err <= 1'b1;
      end
    end
  end

  modulo_fold #(
    .DW     (DW),
    .LAMBDA (LAMBDA)
  ) u_fold (
    .d (d1),
    .f (folded)
  );

  assign resid = folded - d1;

  // Stage 2: registered residual; holds its last value across bubbles.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_out         <= 1'b0;
      residual_diff_out <= '0;
    end else begin
      valid_out <= valid1;
      if (valid1) residual_diff_out <= resid[WIDTH-1:0];
    end
  end

endmodule

// File: tb/tb_modulo_residual_diff.sv
// Randomised and directed checks of modulo_residual_diff (ORDER 1 and 2)
// against a sample-history reference model.
module tb_modulo_residual_diff;

  localparam int W = 16;
  localparam int L = 10;

  logic clk = 1'b0;
  logic reset;
  logic valid_in;
  logic signed [W-1:0] sample_in;
  logic v1, v2, re1, re2;
  logic signed [W-1:0] r1, r2;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  modulo_residual_diff #(.WIDTH(W), .LAMBDA(L), .ORDER(1)) dut1 (
    .clk(clk), .reset(reset), .valid_in(valid_in), .sample_in(sample_in),
    .valid_out(v1), .residual_diff_out(r1), .range_err(re1)
  );

  modulo_residual_diff #(.WIDTH(W), .LAMBDA(L), .ORDER(2)) dut2 (
    .clk(clk), .reset(reset), .valid_in(valid_in), .sample_in(sample_in),
    .valid_out(v2), .residual_diff_out(r2), .range_err(re2)
  );

  // Reference model state: accepted samples since reset and one pending
  // result per order (result of a sample shows up two cycles after it).
  int  hist[$];
  bit  m_rerr;
  bit  pend_v [1:2];
  int  pend_r [1:2];
  bit  exp_v  [1:2];
  int  exp_r  [1:2];

  bit  collect;
  int  obs1[$];
  int  obs2[$];

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int choose(input int n, input int k);
    int c = 1;
    for (int i = 0; i < k; i++) c = c * (n - i) / (i + 1);
    return c;
  endfunction

  // Residual from the mathematical definition, truncated to W bits.
  function automatic int model_resid(input int n, input int s);
    int d, m, f;
    logic signed [W-1:0] t;
    d = s;
    for (int i = 1; i <= n; i++)
      d += ((i % 2) ? -1 : 1) * choose(n, i) * hist[hist.size() - i];
    m = (d + L) % (2 * L);
    if (m < 0) m += 2 * L;
    f = m - L;
    t = W'(f - d);
    return int'(t);
  endfunction

  task automatic step(input bit r, input bit v, input int s);
    reset     = r;
    valid_in  = v;
    sample_in = W'(s);
    @(posedge clk);
    for (int n = 1; n <= 2; n++) begin
      if (r) begin
        exp_v[n]  = 1'b0;
        exp_r[n]  = 0;
        pend_v[n] = 1'b0;
      end else begin
        exp_v[n] = pend_v[n];
        if (pend_v[n]) exp_r[n] = pend_r[n];
        pend_v[n] = 1'b0;
        if (v && hist.size() >= n) begin
          pend_v[n] = 1'b1;
          pend_r[n] = model_resid(n, s);
        end
      end
    end
    if (r) begin
      hist.delete();
      m_rerr = 1'b0;
    end else if (v) begin
      hist.push_back(s);
      if (hist.size() > 4) void'(hist.pop_front());
      if (s < -L || s > L - 1) m_rerr = 1'b1;
    end
    #1;
    check("o1_valid", v1, exp_v[1]);
    check("o1_resid", r1, exp_r[1]);
    check("o1_rerr",  re1, m_rerr);
    check("o2_valid", v2, exp_v[2]);
    check("o2_resid", r2, exp_r[2]);
    check("o2_rerr",  re2, m_rerr);
    if (collect && v1) obs1.push_back(int'(r1));
    if (collect && v2) obs2.push_back(int'(r2));
  endtask

  task automatic start_collect();
    obs1.delete();
    obs2.delete();
    collect = 1'b1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 0);
  endtask

  int seq1[6] = '{3, 5, 9, -9, -9, 9};
  int exp1[5] = '{0, 0, 20, 0, -20};

  initial begin
    collect = 1'b0;
    reset = 1'b1; valid_in = 1'b0; sample_in = '0;
    for (int n = 1; n <= 2; n++) begin
      pend_v[n] = 0; pend_r[n] = 0; exp_v[n] = 0; exp_r[n] = 0;
    end
    m_rerr = 0;
    step(1'b1, 1'b0, 0);
    step(1'b1, 1'b0, 0);

    // Back-to-back sequence, ORDER=1 view.
    start_collect();
    foreach (seq1[i]) step(1'b0, 1'b1, seq1[i]);
    idle(3);
    collect = 1'b0;
    check("seq1_count", obs1.size(), 5);
    for (int i = 0; i < 5; i++)
      if (i < obs1.size()) check("seq1_value", obs1[i], exp1[i]);

    // Fold boundaries at ORDER=1.
    step(1'b1, 1'b0, 0);
    start_collect();
    step(1'b0, 1'b1, 0);  step(1'b0, 1'b1, 10);
    step(1'b1, 1'b0, 0);
    step(1'b0, 1'b1, 0);  step(1'b0, 1'b1, -10);
    step(1'b1, 1'b0, 0);
    step(1'b0, 1'b1, 5);  step(1'b0, 1'b1, -8);
    idle(3);
    collect = 1'b0;
    check("bound_count", obs1.size(), 1);
    if (obs1.size() > 0) check("bound_p5m8", obs1[0], 20);

    // ORDER=2 sequence.
    step(1'b1, 1'b0, 0);
    start_collect();
    step(1'b0, 1'b1, 0); step(1'b0, 1'b1, 9); step(1'b0, 1'b1, -9);
    idle(3);
    collect = 1'b0;
    check("ord2_count", obs2.size(), 1);
    if (obs2.size() > 0) check("ord2_value", obs2[0], 20);

    // Bubbles.
    step(1'b1, 1'b0, 0);
    start_collect();
    step(1'b0, 1'b1, 9); idle(2); step(1'b0, 1'b1, -9);
    idle(3);
    collect = 1'b0;
    check("bubble_count", obs1.size(), 1);
    if (obs1.size() > 0) check("bubble_value", obs1[0], 20);

    // Reset mid-stream discards in-flight data and restarts warm-up.
    step(1'b1, 1'b0, 0);
    step(1'b0, 1'b1, 1); step(1'b0, 1'b1, 7); step(1'b0, 1'b1, -6);
    start_collect();
    step(1'b1, 1'b1, 3);
    step(1'b0, 1'b1, 4); step(1'b0, 1'b1, 6);
    idle(3);
    collect = 1'b0;
    check("rst_count", obs1.size(), 1);
    if (obs1.size() > 0) check("rst_value", obs1[0], 0);

    // Range error is sticky until reset.
    step(1'b0, 1'b1, 12);
    check("rerr_set", re1, 1'b1);
    step(1'b0, 1'b1, 0); step(1'b0, 1'b1, 3);
    check("rerr_hold", re1, 1'b1);
    step(1'b1, 1'b0, 0);
    check("rerr_clear", re1, 1'b0);

    // Randomised traffic with occasional resets and out-of-range samples.
    for (int i = 0; i < 400; i++) begin
      bit r, v;
      int s;
      r = ($urandom_range(0, 49) == 0);
      v = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 9) == 0) s = $urandom_range(0, 80) - 40;
      else                           s = $urandom_range(0, 19) - 10;
      step(r, v, s);
    end
    idle(3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
